// File: rtl/mod47_pkg.sv
// Shared types and constants for the mod-47 residue datapath.
package mod47_pkg;

    localparam int unsigned RES_W = 6;
    localparam int unsigned MOD47 = 47;
    localparam int unsigned INV36 = 17;

    typedef logic [RES_W-1:0] res_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mod47_dbl_add_step.sv
// One Horner step: acc_o = (2*acc_i + (bit_i ? K : 0)) mod MOD, for acc_i < MOD.
module mod47_dbl_add_step #(
    parameter int unsigned W   = 6,
    parameter int unsigned MOD = 47,
    parameter int unsigned K   = 17
) (
    input  logic [W-1:0] acc_i,
    input  logic         bit_i,
    output logic [W-1:0] acc_o
);

    localparam int unsigned TW = W + 2;

    logic [TW-1:0] t;
    logic [TW-1:0] t1;

    // t < 3*MOD, so one 2*MOD subtract followed by one MOD subtract is an exact reduction
    always_comb begin
        t     = {1'b0, acc_i, 1'b0} + (bit_i ? TW'(K) : TW'(0));
        t1    = (t >= TW'(2 * MOD)) ? (t - TW'(2 * MOD)) : t;
        acc_o = (t1 >= TW'(MOD)) ? W'(t1 - TW'(MOD)) : W'(t1);
    end

endmodule

// File: rtl/mod47_descale_36.sv
// Bit-serial mod-47 descale: out_z = (in_x * 17) mod 47, undoing the x36 stage.
// Optional MOD47_RANGE_CHECK_EN adds out_err flagging operands >= MOD.
module mod47_descale_36
    import mod47_pkg::*;
#(
    parameter int unsigned W   = RES_W,
    parameter int unsigned MOD = MOD47,
    parameter int unsigned K   = INV36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef MOD47_RANGE_CHECK_EN
    output logic         out_err,
`endif
    output logic [W-1:0] out_z
);

    localparam int unsigned CNT_W = $clog2(W);

    state_t            state_q, state_d;
    logic [W-1:0]      sh_q, sh_d;
    logic [W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]      z_d;
    logic              in_ready_d;
    logic              out_valid_d;
    logic [W-1:0]      step_acc;
`ifdef MOD47_RANGE_CHECK_EN
    logic              err_d;
`endif

    mod47_dbl_add_step #(
        .W   (W),
        .MOD (MOD),
        .K   (K)
    ) u_step (
        .acc_i (acc_q),
        .bit_i (sh_q[cnt_q]),
        .acc_o (step_acc)
    );

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        z_d     = out_z;
`ifdef MOD47_RANGE_CHECK_EN
        err_d   = out_err;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sh_d    = in_x;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(W - 1);
`ifdef MOD47_RANGE_CHECK_EN
                    err_d   = (in_x >= W'(MOD));
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = step_acc;
                if (cnt_q == '0) begin
                    z_d     = step_acc;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_z     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef MOD47_RANGE_CHECK_EN
            out_err   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_z     <= z_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
`ifdef MOD47_RANGE_CHECK_EN
            out_err   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mod47_descale_36.sv
// Directed self-checking bench for mod47_descale_36 (optionally with MOD47_RANGE_CHECK_EN).
module tb_mod47_descale_36;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_x;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_z;
`ifdef MOD47_RANGE_CHECK_EN
    logic       out_err;
`endif

    int n_cmp;
    int n_fail;

    mod47_descale_36 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef MOD47_RANGE_CHECK_EN
        .out_err   (out_err),
`endif
        .out_z     (out_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; sample/drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_z !== 6'd0) begin n_fail++; $display("FAIL reset_out_z got %0d want 0", out_z); end
`ifdef MOD47_RANGE_CHECK_EN
        n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err got %b want 0", out_err); end
`endif
    endtask

    task automatic test_directed();
        logic [5:0] xs  [7] = '{6'd36, 6'd1, 6'd2, 6'd0, 6'd46, 6'd50, 6'd63};
        logic [5:0] exp [7] = '{6'd1, 6'd17, 6'd34, 6'd0, 6'd30, 6'd4, 6'd37};
        logic       eerr[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int cyc;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_x = xs[i];
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir_ready x=%0d got %b want 1", xs[i], in_ready); end
            tick();
            in_valid = 1'b0; in_x = ~xs[i];
            cyc = 0;
            while (out_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
            n_cmp++; if (cyc !== 6) begin n_fail++; $display("FAIL dir_latency x=%0d got %0d want 6", xs[i], cyc); end
            n_cmp++; if (out_z !== exp[i]) begin n_fail++; $display("FAIL dir_z x=%0d got %0d want %0d", xs[i], out_z, exp[i]); end
`ifdef MOD47_RANGE_CHECK_EN
            n_cmp++; if (out_err !== eerr[i]) begin n_fail++; $display("FAIL dir_err x=%0d got %b want %b", xs[i], out_err, eerr[i]); end
`endif
            tick();
            n_cmp++; if (out_valid !== 1'b0 || out_z !== exp[i]) begin
                n_fail++; $display("FAIL dir_idle x=%0d got valid=%b z=%0d want valid=0 z=%0d", xs[i], out_valid, out_z, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready = 1'b0;
        in_valid = 1'b1; in_x = 6'd46;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        n_cmp++; if (cyc !== 6) begin n_fail++; $display("FAIL bp_latency got %0d want 6", cyc); end
        in_valid = 1'b1; in_x = 6'd1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_z !== 6'd30 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold cyc=%0d got valid=%b z=%0d ready=%b want 1/30/0", i, out_valid, out_z, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accept got ready=%b want 0", in_ready); end
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        n_cmp++; if (cyc !== 6 || out_z !== 6'd17) begin
            n_fail++; $display("FAIL bp_second got lat=%0d z=%0d want 6/17", cyc, out_z);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int pulses;
        int cyc;
        out_ready = 1'b1;
        pulses = 0;
        in_valid = 1'b1; in_x = 6'd36;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid === 1'b1) pulses++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_z !== 6'd0) begin
            n_fail++; $display("FAIL rstmid_state got ready=%b valid=%b z=%0d want 1/0/0", in_ready, out_valid, out_z);
        end
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1) pulses++;
            tick();
        end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL rstmid_pulse got %0d want 0", pulses); end
        in_valid = 1'b1; in_x = 6'd2;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        n_cmp++; if (cyc !== 6 || out_z !== 6'd34) begin
            n_fail++; $display("FAIL rstmid_next got lat=%0d z=%0d want 6/34", cyc, out_z);
        end
        tick();
    endtask

    task automatic test_exhaustive();
        int cyc;
        int stall;
        int want;
        logic [5:0] held;
        for (int x = 0; x < 64; x++) begin
            want = (x * 17) % 47;
            in_valid = 1'b1; in_x = 6'(x);
            cyc = 0;
            while (in_ready !== 1'b1 && cyc < 20) begin
                out_ready = 1'b1;
                tick(); cyc++;
            end
            tick();
            in_valid = 1'b0;
            cyc = 0;
            while (out_valid !== 1'b1 && cyc < 20) begin
                out_ready = 1'($urandom_range(0, 1));
                tick(); cyc++;
            end
            n_cmp++; if (out_valid !== 1'b1 || int'(out_z) !== want) begin
                n_fail++; $display("FAIL exh_z x=%0d got valid=%b z=%0d want %0d", x, out_valid, out_z, want);
            end
            n_cmp++; if ((int'(out_z) * 36) % 47 !== x % 47) begin
                n_fail++; $display("FAIL exh_inv x=%0d got %0d want %0d", x, (int'(out_z) * 36) % 47, x % 47);
            end
`ifdef MOD47_RANGE_CHECK_EN
            n_cmp++; if (out_err !== (x >= 47)) begin
                n_fail++; $display("FAIL exh_err x=%0d got %b want %b", x, out_err, (x >= 47));
            end
`endif
            held = out_z;
            stall = $urandom_range(0, 3);
            out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                tick();
                if (out_valid !== 1'b1 || out_z !== held) begin
                    n_fail++; $display("FAIL exh_stall x=%0d got valid=%b z=%0d want 1/%0d", x, out_valid, out_z, held);
                end
                n_cmp++;
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
